// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions for the master and slave blocks.
// Holds the FSM state encoding and strobe-width helpers.
package axi_lite_pkg;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4
   } axil_state_t;

   function automatic int axil_strb_w(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI-Lite master: turns one host command into one AXI-Lite
// transaction and returns a one-cycle response pulse.
// Ports: clk/rst (async, active-high); cmd_* host request;
// rsp_* response; AW/W/B/AR/R AXI-Lite channels.
// Option: define AXIL_MASTER_TIMEOUT_EN for a response watchdog
// that aborts after TIMEOUT_CYCLES stalled cycles (rsp_err = 1).
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    WVALID,
   input  logic                    WREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic                    RVALID,
   output logic                    RREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA
);

   localparam int SW = axil_strb_w(DATA_WIDTH);

   axil_state_t           state;
   logic                  aw_done;
   logic                  w_done;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [SW-1:0]         wstrb_q;
   logic                  tmo_hit;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   assign cmd_ready = (state == ST_IDLE);
   assign AWVALID   = (state == ST_WRITE) && !aw_done;
   assign WVALID    = (state == ST_WRITE) && !w_done;
   assign BREADY    = (state == ST_WRESP);
   assign ARVALID   = (state == ST_RADDR);
   assign RREADY    = (state == ST_RDATA);
   assign AWADDR    = addr_q;
   assign ARADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign b_hs  = BVALID && BREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;
   logic          any_hs;
   logic          err_q;

   assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
   // Fires on the last stalled cycle, so VALID/READY stay up for
   // exactly TIMEOUT_CYCLES cycles without progress.
   assign tmo_hit = (state != ST_IDLE) && !any_hs &&
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign rsp_err = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= tmo_hit;
         if (state == ST_IDLE || any_hs)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = |TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (tmo_hit) begin
            state     <= ST_IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (cmd_valid) begin
                     addr_q  <= cmd_addr;
                     wdata_q <= cmd_wdata;
                     wstrb_q <= cmd_wstrb;
                     state   <= cmd_write ? ST_WRITE : ST_RADDR;
                  end
               end
               ST_WRITE: begin
                  if (aw_hs) aw_done <= 1'b1;
                  if (w_hs)  w_done  <= 1'b1;
                  // AW and W may complete in either order or together.
                  if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                     state   <= ST_WRESP;
                  end
               end
               ST_WRESP: begin
                  if (BVALID) begin
                     rsp_valid <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               ST_RADDR: begin
                  if (ARREADY) state <= ST_RDATA;
               end
               ST_RDATA: begin
                  if (RVALID) begin
                     rsp_rdata <= RDATA;
                     rsp_valid <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: directed cases plus
// random traffic against a word-memory reference model.
module tb_axi_lite_master;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        AWVALID, AWREADY;
   logic [7:0]  AWADDR;
   logic        WVALID, WREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        BVALID, BREADY;
   logic        ARVALID, ARREADY;
   logic [7:0]  ARADDR;
   logic        RVALID, RREADY;
   logic [31:0] RDATA;

   axi_lite_master #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
      .WSTRB(WSTRB),
      .BVALID(BVALID), .BREADY(BREADY),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA)
   );

   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [7:0]  s_addr;
   logic [31:0] s_data, r_data;
   logic [3:0]  s_strb;
   logic [31:0] smem [0:63];
   logic        a_have, w_have, s_commit;
   logic [7:0]  c_addr;
   logic [31:0] c_data;
   logic [3:0]  c_strb;

   assign AWREADY  = AWVALID && (aw_wait >= aw_dly);
   assign WREADY   = WVALID && (w_wait >= w_dly);
   assign ARREADY  = ARVALID && (ar_wait >= ar_dly);
   assign BVALID   = b_pend && (b_wait >= b_dly);
   assign RVALID   = r_pend && (r_wait >= r_dly);
   assign RDATA    = r_data;
   assign a_have   = aw_got || (AWVALID && AWREADY);
   assign w_have   = w_got || (WVALID && WREADY);
   assign s_commit = a_have && w_have && !b_pend;
   assign c_addr   = aw_got ? s_addr : AWADDR;
   assign c_data   = w_got ? s_data : WDATA;
   assign c_strb   = w_got ? s_strb : WSTRB;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0;
         ar_wait <= 0; r_wait <= 0;
         aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
         s_addr <= '0; s_data <= '0; s_strb <= '0;
         r_data <= '0;
      end else begin
         aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
         w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
         ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
         b_wait  <= (b_pend && !(BVALID && BREADY)) ? b_wait + 1 : 0;
         r_wait  <= (r_pend && !(RVALID && RREADY)) ? r_wait + 1 : 0;
         if (s_commit) begin
            aw_got <= 0;
            w_got  <= 0;
            b_pend <= 1;
         end else begin
            if (AWVALID && AWREADY) begin
               aw_got <= 1;
               s_addr <= AWADDR;
            end
            if (WVALID && WREADY) begin
               w_got  <= 1;
               s_data <= WDATA;
               s_strb <= WSTRB;
            end
         end
         if (BVALID && BREADY) b_pend <= 0;
         if (ARVALID && ARREADY) begin
            r_pend <= 1;
            r_data <= smem[ARADDR[7:2]];
         end else if (RVALID && RREADY) begin
            r_pend <= 0;
         end
      end
   end

   always @(posedge clk) begin
      if (s_commit)
         for (int i = 0; i < 4; i++)
            if (c_strb[i]) smem[c_addr[7:2]][8*i +: 8] <= c_data[8*i +: 8];
   end

   // ---------------- protocol monitor ----------------
   int aw_hi = 0, w_hi = 0, ar_hi = 0, rr_hi = 0;
   int rsp_cnt = 0, unstable = 0;
   logic        pv_aw = 0, pv_w = 0, pv_ar = 0;
   logic [7:0]  p_awaddr, p_araddr;
   logic [35:0] p_w;

   always @(posedge clk) begin
      if (AWVALID) aw_hi <= aw_hi + 1;
      if (WVALID)  w_hi  <= w_hi + 1;
      if (ARVALID) ar_hi <= ar_hi + 1;
      if (RREADY)  rr_hi <= rr_hi + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (rst) begin
         pv_aw <= 0; pv_w <= 0; pv_ar <= 0;
      end else begin
         if ((pv_aw && !(AWVALID && AWADDR == p_awaddr)) ||
             (pv_w && !(WVALID && {WSTRB, WDATA} == p_w)) ||
             (pv_ar && !(ARVALID && ARADDR == p_araddr)))
            unstable <= unstable + 1;
         pv_aw <= AWVALID && !AWREADY;
         pv_w  <= WVALID && !WREADY;
         pv_ar <= ARVALID && !ARREADY;
      end
      p_awaddr <= AWADDR;
      p_araddr <= ARADDR;
      p_w      <= {WSTRB, WDATA};
   end

   // ---------------- checking ----------------
   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [0:63];

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] m = 0;
      for (int i = 0; i < 4; i++)
         if (s[i]) m = m | (32'hFF << (8 * i));
      return (old & ~m) | (d & m);
   endfunction

   int          last_lat;
   logic        last_err, last_crbad;
   logic [31:0] last_rd;

   task automatic run(input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      cmd_valid = 1; cmd_write = wr; cmd_addr = a;
      cmd_wdata = d; cmd_wstrb = s;
      @(posedge clk);
      last_lat = 0;
      last_crbad = 0;
      do begin
         @(negedge clk);
         cmd_valid = 0;
         last_lat++;
         if (!rsp_valid && cmd_ready) last_crbad = 1;
      end while (!rsp_valid && last_lat < 400);
      if (!rsp_valid) chk("rsp_wait_expired", 0, 1);
      last_err = rsp_err;
      last_rd  = rsp_rdata;
   endtask

   task automatic xfer(input string tag, input logic wr,
                       input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      int c0 = rsp_cnt;
      int u0 = unstable;
      logic [31:0] exp = ref_mem[a[7:2]];
      run(wr, a, d, s);
      if (wr) ref_mem[a[7:2]] = merge(exp, d, s);
      chk({tag, "_err"}, 64'(last_err), 0);
      if (!wr) chk({tag, "_rdata"}, 64'(last_rd), 64'(exp));
      @(posedge clk);
      #1;
      chk({tag, "_one_rsp"}, 64'(rsp_cnt - c0), 1);
      chk({tag, "_stable"}, 64'(unstable - u0), 0);
   endtask

   initial begin
      int a0, w0, r0, c0;
      int n;
      logic        wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outs",
          64'({AWVALID, WVALID, BREADY, ARVALID, RREADY,
               rsp_valid, rsp_err}), 0);
      chk("reset_rdata", 64'(rsp_rdata), 0);
      rst = 0;
      @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 1);

      // Basic write then read, slaves always ready
      xfer("wr04", 1, 8'h04, 32'hDEADBEEF, 4'hF);
      chk("wr04_lat", 64'(last_lat), 3);
      chk("wr04_slave", 64'(smem[1]), 64'h0000_0000_DEAD_BEEF);
      xfer("rd04", 0, 8'h04, 32'h0, 4'h0);
      chk("rd04_lat", 64'(last_lat), 3);
      chk("rd04_val", 64'(last_rd), 64'h0000_0000_DEAD_BEEF);

      // AWREADY delayed 5 cycles, WREADY immediate
      aw_dly = 5;
      a0 = aw_hi; w0 = w_hi;
      xfer("awdly", 1, 8'h08, 32'h0BADF00D, 4'hF);
      chk("awdly_awvalid_cyc", 64'(aw_hi - a0), 6);
      chk("awdly_wvalid_cyc", 64'(w_hi - w0), 1);
      chk("awdly_lat", 64'(last_lat), 8);
      aw_dly = 0;

      // Partial strobe merge
      xfer("strb_base", 1, 8'h10, 32'hAABBCCDD, 4'hF);
      xfer("strb_part", 1, 8'h10, 32'h11223344, 4'h3);
      xfer("strb_rd", 0, 8'h10, 32'h0, 4'h0);
      chk("strb_val", 64'(last_rd), 64'h0000_0000_AABB_3344);

      // RVALID delayed 10 cycles
      r_dly = 10;
      r0 = rr_hi;
      xfer("rdly", 0, 8'h04, 32'h0, 4'h0);
      chk("rdly_lat", 64'(last_lat), 13);
      chk("rdly_rready_cyc", 64'(rr_hi - r0), 11);
      chk("rdly_cmd_ready_low", 64'(last_crbad), 0);
      r_dly = 0;

      // Reset while waiting in WRESP
      b_dly = 20;
      c0 = rsp_cnt;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h20;
      cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!BREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wresp_reached", 64'(BREADY), 1);
      ref_mem[8] = 32'h12345678;
      rst = 1;
      #1;
      chk("rst_mid_outs",
          64'({AWVALID, WVALID, BREADY, ARVALID, RREADY,
               rsp_valid, rsp_err}), 0);
      repeat (2) @(negedge clk);
      rst = 0;
      b_dly = 0;
      repeat (3) @(negedge clk);
      chk("rst_mid_no_rsp", 64'(rsp_cnt - c0), 0);
      chk("rst_mid_idle", 64'(cmd_ready), 1);

`ifdef AXIL_MASTER_TIMEOUT_EN
      // Watchdog with ARREADY held low
      ar_dly = 100000;
      a0 = ar_hi;
      run(0, 8'h04, 32'h0, 4'h0);
      chk("tmo_err", 64'(last_err), 1);
      chk("tmo_lat", 64'(last_lat), TMO + 1);
      chk("tmo_rdata", 64'(last_rd), 0);
      @(negedge clk);
      chk("tmo_arvalid_low", 64'(ARVALID), 0);
      chk("tmo_arvalid_cyc", 64'(ar_hi - a0), TMO);
      ar_dly = 0;
`endif

      // Fill every word, then random traffic
      for (int i = 0; i < 16; i++)
         xfer("fill", 1, 8'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         a = 8'($urandom_range(0, 15) * 4);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         aw_dly = $urandom_range(0, 3);
         w_dly = $urandom_range(0, 3);
         b_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3);
         r_dly = $urandom_range(0, 3);
         xfer(wr ? "rnd_wr" : "rnd_rd", wr, a, d, s);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

endmodule
